// File: rtl/bsr_idx_loader.sv
// Job front end for spdot_bsr_core: takes a job shape, streams block indices into
// the index RAM, launches the core once, and returns its checksum or an error code.
module bsr_idx_loader #(
   parameter int IDX_DEPTH = 256,
   parameter int ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [15:0]       cfg_m_rows,
   input  logic [15:0]       cfg_head_dim_d,
   input  logic [15:0]       cfg_s_tokens,
   input  logic [15:0]       cfg_block_size,
   input  logic              idx_in_valid,
   output logic              idx_in_ready,
   input  logic [15:0]       idx_in_data,
   input  logic              idx_in_last,
   output logic              idx_wr_en,
   output logic [ADDR_W-1:0] idx_wr_addr,
   output logic [15:0]       idx_wr_data,
   output logic              core_start,
   output logic [15:0]       core_m_rows,
   output logic [15:0]       core_head_dim_d,
   output logic [15:0]       core_s_tokens,
   output logic [15:0]       core_block_size,
   input  logic              core_busy,
   input  logic              core_done,
   input  logic [63:0]       core_checksum,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              result_err,
   output logic [1:0]        result_code,
   output logic [63:0]       result_checksum,
   output logic [3:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready;
   // valid-side payloads must stay stable while valid is high and ready is low.

   localparam int CNT_W = 17;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_CAPT   = 3'd4;
   localparam logic [2:0] ST_RESULT = 3'd5;

   localparam logic [1:0] RC_OK      = 2'd0;
   localparam logic [1:0] RC_SIZE    = 2'd1;
   localparam logic [1:0] RC_EARLY   = 2'd2;
   localparam logic [1:0] RC_MISSING = 2'd3;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  n_blk_q, n_blk_d;
   logic [15:0]       m_rows_q, m_rows_d;
   logic [15:0]       head_dim_q, head_dim_d;
   logic [15:0]       s_tokens_q, s_tokens_d;
   logic [15:0]       block_size_q, block_size_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data_q, wr_data_d;
   logic [1:0]        code_q, code_d;
   logic [63:0]       csum_q, csum_d;

   logic [CNT_W-1:0]  s_ext, b_ext, n_blk_c;
   logic              last_slot;

   // ceil(s/b) as (s+b-1)/b; the 17-bit sum cannot overflow for 16-bit operands.
   always_comb begin
      s_ext = {1'b0, cfg_s_tokens};
      b_ext = {1'b0, cfg_block_size};
      n_blk_c = CNT_W'(1);
      if (cfg_block_size != 16'd0) begin
         n_blk_c = (s_ext + b_ext - CNT_W'(1)) / b_ext;
      end
   end

   assign last_slot = (wr_ptr_q == n_blk_q - CNT_W'(1));

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      n_blk_d      = n_blk_q;
      m_rows_d     = m_rows_q;
      head_dim_d   = head_dim_q;
      s_tokens_d   = s_tokens_q;
      block_size_d = block_size_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      code_d       = code_q;
      csum_d       = csum_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               m_rows_d     = cfg_m_rows;
               head_dim_d   = cfg_head_dim_d;
               s_tokens_d   = cfg_s_tokens;
               block_size_d = cfg_block_size;
               n_blk_d      = n_blk_c;
               wr_ptr_d     = '0;
               if (cfg_s_tokens == 16'd0 || n_blk_c > CNT_W'(IDX_DEPTH)) begin
                  state_d = ST_RESULT;
                  code_d  = RC_SIZE;
                  csum_d  = '0;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (idx_in_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = ADDR_W'(wr_ptr_q);
               wr_data_d = idx_in_data;
               wr_ptr_d  = wr_ptr_q + CNT_W'(1);
               if (last_slot && idx_in_last) begin
                  state_d = ST_START;
               end else if (last_slot || idx_in_last) begin
                  state_d = ST_RESULT;
                  code_d  = idx_in_last ? RC_EARLY : RC_MISSING;
                  csum_d  = '0;
               end
            end
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT: begin
            if (core_done) state_d = ST_CAPT;
         end
         ST_CAPT: begin
            csum_d  = core_checksum;
            code_d  = RC_OK;
            state_d = ST_RESULT;
         end
         ST_RESULT: begin
            if (result_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         n_blk_q      <= '0;
         m_rows_q     <= '0;
         head_dim_q   <= '0;
         s_tokens_q   <= '0;
         block_size_q <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         code_q       <= RC_OK;
         csum_q       <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         n_blk_q      <= n_blk_d;
         m_rows_q     <= m_rows_d;
         head_dim_q   <= head_dim_d;
         s_tokens_q   <= s_tokens_d;
         block_size_q <= block_size_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         code_q       <= code_d;
         csum_q       <= csum_d;
      end
   end

   assign cfg_ready       = (state_q == ST_IDLE);
   assign idx_in_ready    = (state_q == ST_LOAD);
   assign core_start      = (state_q == ST_START);
   assign result_valid    = (state_q == ST_RESULT);
   assign result_err      = result_valid && (code_q != RC_OK);
   assign result_code     = code_q;
   assign result_checksum = csum_q;
   assign idx_wr_en       = wr_en_q;
   assign idx_wr_addr     = wr_addr_q;
   assign idx_wr_data     = wr_data_q;
   assign core_m_rows     = m_rows_q;
   assign core_head_dim_d = head_dim_q;
   assign core_s_tokens   = s_tokens_q;
   assign core_block_size = block_size_q;
   // Core busy rides along with the state so a monitor sees both in one word.
   assign dbg_state       = {core_busy, state_q};

endmodule

// File: tb/tb_bsr_idx_loader.sv
// Directed bench for bsr_idx_loader: nominal, sizing, error, backpressure and reset jobs.
module tb_bsr_idx_loader;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cfg_valid, cfg_ready;
   logic [15:0] cfg_m_rows, cfg_head_dim_d, cfg_s_tokens, cfg_block_size;
   logic        idx_in_valid, idx_in_ready, idx_in_last;
   logic [15:0] idx_in_data;
   logic        idx_wr_en;
   logic [15:0] idx_wr_addr, idx_wr_data;
   logic        core_start;
   logic [15:0] core_m_rows, core_head_dim_d, core_s_tokens, core_block_size;
   logic        core_busy, core_done;
   logic [63:0] core_checksum;
   logic        result_valid, result_ready, result_err;
   logic [1:0]  result_code;
   logic [63:0] result_checksum;
   logic [3:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int start_cnt = 0;
   int wr_cnt    = 0;

   localparam logic [63:0] JUNK = 64'h1111_2222_3333_4444;

   bsr_idx_loader #(.IDX_DEPTH(256), .ADDR_W(16)) dut (
      .clk(clk), .rstn(rstn),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_m_rows(cfg_m_rows), .cfg_head_dim_d(cfg_head_dim_d),
      .cfg_s_tokens(cfg_s_tokens), .cfg_block_size(cfg_block_size),
      .idx_in_valid(idx_in_valid), .idx_in_ready(idx_in_ready),
      .idx_in_data(idx_in_data), .idx_in_last(idx_in_last),
      .idx_wr_en(idx_wr_en), .idx_wr_addr(idx_wr_addr), .idx_wr_data(idx_wr_data),
      .core_start(core_start),
      .core_m_rows(core_m_rows), .core_head_dim_d(core_head_dim_d),
      .core_s_tokens(core_s_tokens), .core_block_size(core_block_size),
      .core_busy(core_busy), .core_done(core_done), .core_checksum(core_checksum),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_err(result_err), .result_code(result_code),
      .result_checksum(result_checksum), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (core_start) start_cnt++;
      if (idx_wr_en)  wr_cnt++;
   end

   // drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cfg(input logic [15:0] m, input logic [15:0] d,
                           input logic [15:0] s, input logic [15:0] b);
      cfg_m_rows = m; cfg_head_dim_d = d; cfg_s_tokens = s; cfg_block_size = b;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [15:0] data, input logic last);
      idx_in_valid = 1'b1; idx_in_data = data; idx_in_last = last;
      tick();
      idx_in_valid = 1'b0; idx_in_last = 1'b0;
   endtask

   // From the START cycle: a few busy cycles, a done pulse, checksum valid only
   // the following cycle; returns in the first RESULT cycle.
   task automatic run_core(input logic [63:0] csum);
      tick();
      core_busy = 1'b1;
      tick();
      tick();
      core_done = 1'b1; core_checksum = JUNK;
      tick();
      core_done = 1'b0; core_checksum = csum;
      tick();
      core_checksum = ~csum; core_busy = 1'b0;
   endtask

   task automatic ack();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   // tests
   task automatic test_reset();
      rstn = 1'b0;
      #22;
      n_checks++;
      if ({cfg_ready, idx_in_ready, idx_wr_en, core_start, result_valid, result_err} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_ctl: cfg_rdy/idx_rdy/wr_en/start/rv/err=%b exp 100000",
                  {cfg_ready, idx_in_ready, idx_wr_en, core_start, result_valid, result_err});
      end
      n_checks++;
      if ({result_code, result_checksum, core_m_rows, core_s_tokens, idx_wr_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: code=%0d csum=%h m=%h s=%h addr=%h exp all 0",
                  result_code, result_checksum, core_m_rows, core_s_tokens, idx_wr_addr);
      end
      @(negedge clk);
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_nominal();
      int s0, w0;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      n_checks++;
      if (cfg_ready !== 1'b1 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL done_in_idle: cfg_ready=%b rv=%b exp 1/0", cfg_ready, result_valid);
      end
      s0 = start_cnt; w0 = wr_cnt;
      send_cfg(16'd1, 16'd2, 16'd8, 16'd4);
      n_checks++;
      if ({idx_in_ready, cfg_ready} !== 2'b10 ||
          {core_m_rows, core_head_dim_d, core_s_tokens, core_block_size} !== {16'd1, 16'd2, 16'd8, 16'd4}) begin
         n_fail++;
         $display("FAIL nom_load: idx_rdy=%b cfg_rdy=%b shape=%0d/%0d/%0d/%0d exp 1/0 1/2/8/4",
                  idx_in_ready, cfg_ready, core_m_rows, core_head_dim_d, core_s_tokens, core_block_size);
      end
      core_done = 1'b1;
      send_beat(16'h0003, 1'b0);
      core_done = 1'b0;
      n_checks++;
      if ({idx_wr_en, core_start} !== 2'b10 || idx_wr_addr !== 16'd0 || idx_wr_data !== 16'h0003) begin
         n_fail++;
         $display("FAIL nom_wr0: wr_en=%b start=%b addr=%h data=%h exp 1/0/0000/0003",
                  idx_wr_en, core_start, idx_wr_addr, idx_wr_data);
      end
      send_beat(16'h0005, 1'b1);
      n_checks++;
      if ({idx_wr_en, core_start} !== 2'b11 || idx_wr_addr !== 16'd1 || idx_wr_data !== 16'h0005) begin
         n_fail++;
         $display("FAIL nom_wr1: wr_en=%b start=%b addr=%h data=%h exp 1/1/0001/0005",
                  idx_wr_en, core_start, idx_wr_addr, idx_wr_data);
      end
      tick();
      core_busy = 1'b1;
      n_checks++;
      if ({idx_wr_en, core_start, idx_in_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL nom_wait: wr_en/start/idx_rdy=%b exp 000", {idx_wr_en, core_start, idx_in_ready});
      end
      repeat (4) tick();
      core_done = 1'b1; core_checksum = JUNK;
      tick();
      core_done = 1'b0; core_checksum = 64'hDEAD_BEEF_0123_4567;
      n_checks++;
      if (result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL nom_capt: result_valid=%b exp 0", result_valid);
      end
      tick();
      core_checksum = JUNK; core_busy = 1'b0;
      n_checks++;
      if ({result_valid, result_err} !== 2'b10 || result_code !== 2'd0 ||
          result_checksum !== 64'hDEAD_BEEF_0123_4567) begin
         n_fail++;
         $display("FAIL nom_result: rv=%b err=%b code=%0d csum=%h exp 1/0/0/deadbeef01234567",
                  result_valid, result_err, result_code, result_checksum);
      end
      n_checks++;
      if (start_cnt - s0 !== 1 || wr_cnt - w0 !== 2) begin
         n_fail++;
         $display("FAIL nom_counts: starts=%0d writes=%0d exp 1/2", start_cnt - s0, wr_cnt - w0);
      end
      ack();
      n_checks++;
      if ({result_valid, cfg_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL nom_idle: rv=%b cfg_ready=%b exp 0/1", result_valid, cfg_ready);
      end
   endtask

   task automatic test_block_size_zero();
      send_cfg(16'd4, 16'd4, 16'd5, 16'd0);
      send_beat(16'h00AA, 1'b1);
      n_checks++;
      if ({idx_wr_en, core_start} !== 2'b11 || idx_wr_addr !== 16'd0 || idx_wr_data !== 16'h00AA) begin
         n_fail++;
         $display("FAIL bs0_launch: wr_en=%b start=%b addr=%h data=%h exp 1/1/0000/00aa",
                  idx_wr_en, core_start, idx_wr_addr, idx_wr_data);
      end
      run_core(64'h0000_0000_0000_00AB);
      n_checks++;
      if (result_valid !== 1'b1 || result_code !== 2'd0 || result_checksum !== 64'hAB) begin
         n_fail++;
         $display("FAIL bs0_result: rv=%b code=%0d csum=%h exp 1/0/ab", result_valid, result_code, result_checksum);
      end
      ack();
   endtask

   task automatic test_sizing();
      int s0, w0;
      s0 = start_cnt; w0 = wr_cnt;
      send_cfg(16'd1, 16'd1, 16'd1000, 16'd2);
      n_checks++;
      if ({result_valid, result_err, cfg_ready, idx_in_ready} !== 4'b1100 ||
          result_code !== 2'd1 || result_checksum !== 64'd0) begin
         n_fail++;
         $display("FAIL overflow_500: rv/err/cfg_rdy/idx_rdy=%b code=%0d csum=%h exp 1100/1/0",
                  {result_valid, result_err, cfg_ready, idx_in_ready}, result_code, result_checksum);
      end
      ack();
      send_cfg(16'd1, 16'd1, 16'd514, 16'd2);
      n_checks++;
      if (result_valid !== 1'b1 || result_code !== 2'd1) begin
         n_fail++;
         $display("FAIL overflow_257: rv=%b code=%0d exp 1/1", result_valid, result_code);
      end
      ack();
      n_checks++;
      if (start_cnt - s0 !== 0 || wr_cnt - w0 !== 0) begin
         n_fail++;
         $display("FAIL overflow_side: starts=%0d writes=%0d exp 0/0", start_cnt - s0, wr_cnt - w0);
      end
      // Exactly IDX_DEPTH blocks is accepted and fills the last address.
      w0 = wr_cnt;
      send_cfg(16'd1, 16'd1, 16'd512, 16'd2);
      n_checks++;
      if (idx_in_ready !== 1'b1 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL depth_256_load: idx_rdy=%b rv=%b exp 1/0", idx_in_ready, result_valid);
      end
      for (int i = 0; i < 256; i++) begin
         send_beat(16'(i) ^ 16'h5A5A, (i == 255));
      end
      n_checks++;
      if ({idx_wr_en, core_start} !== 2'b11 || idx_wr_addr !== 16'd255 || idx_wr_data !== 16'h5AA5) begin
         n_fail++;
         $display("FAIL depth_256_last: wr_en=%b start=%b addr=%h data=%h exp 1/1/00ff/5aa5",
                  idx_wr_en, core_start, idx_wr_addr, idx_wr_data);
      end
      run_core(64'hCAFE_F00D_0000_0256);
      n_checks++;
      if (result_code !== 2'd0 || result_checksum !== 64'hCAFE_F00D_0000_0256 || wr_cnt - w0 !== 256) begin
         n_fail++;
         $display("FAIL depth_256_result: code=%0d csum=%h writes=%0d exp 0/cafef00d00000256/256",
                  result_code, result_checksum, wr_cnt - w0);
      end
      ack();
   endtask

   task automatic test_last_errors();
      int s0, w0;
      s0 = start_cnt; w0 = wr_cnt;
      send_cfg(16'd1, 16'd1, 16'd16, 16'd4);
      send_beat(16'h0011, 1'b0);
      send_beat(16'h0022, 1'b1);
      n_checks++;
      if ({idx_wr_en, result_valid, result_err, core_start} !== 4'b1110 ||
          idx_wr_addr !== 16'd1 || result_code !== 2'd2 || result_checksum !== 64'd0) begin
         n_fail++;
         $display("FAIL last_early: wr_en/rv/err/start=%b addr=%h code=%0d csum=%h exp 1110/0001/2/0",
                  {idx_wr_en, result_valid, result_err, core_start}, idx_wr_addr, result_code, result_checksum);
      end
      ack();
      send_cfg(16'd1, 16'd1, 16'd8, 16'd4);
      send_beat(16'h0033, 1'b0);
      send_beat(16'h0044, 1'b0);
      n_checks++;
      if ({idx_wr_en, result_valid, result_err, core_start} !== 4'b1110 ||
          idx_wr_data !== 16'h0044 || result_code !== 2'd3) begin
         n_fail++;
         $display("FAIL last_missing: wr_en/rv/err/start=%b data=%h code=%0d exp 1110/0044/3",
                  {idx_wr_en, result_valid, result_err, core_start}, idx_wr_data, result_code);
      end
      ack();
      n_checks++;
      if (start_cnt - s0 !== 0 || wr_cnt - w0 !== 4) begin
         n_fail++;
         $display("FAIL last_counts: starts=%0d writes=%0d exp 0/4", start_cnt - s0, wr_cnt - w0);
      end
   endtask

   task automatic test_backpressure();
      send_cfg(16'd2, 16'd3, 16'd4, 16'd4);
      send_beat(16'h0099, 1'b1);
      run_core(64'h0BAD_C0DE_5555_AAAA);
      cfg_valid = 1'b1; cfg_m_rows = 16'd9; cfg_s_tokens = 16'd0; cfg_block_size = 16'd1;
      for (int i = 0; i < 10; i++) begin
         core_checksum = JUNK + 64'(i);
         tick();
         n_checks++;
         if ({result_valid, result_err, cfg_ready, idx_in_ready} !== 4'b1000 || result_code !== 2'd0 ||
             result_checksum !== 64'h0BAD_C0DE_5555_AAAA || core_m_rows !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: rv/err/cfg_rdy/idx_rdy=%b code=%0d csum=%h m=%0d exp 1000/0/0badc0de5555aaaa/2",
                     i, {result_valid, result_err, cfg_ready, idx_in_ready}, result_code, result_checksum, core_m_rows);
         end
      end
      cfg_valid = 1'b0;
      ack();
      // New cfg in the very first IDLE cycle (empty job).
      send_cfg(16'd6, 16'd6, 16'd0, 16'd4);
      n_checks++;
      if ({result_valid, result_err} !== 2'b11 || result_code !== 2'd1 || core_m_rows !== 16'd6) begin
         n_fail++;
         $display("FAIL b2b_empty: rv/err=%b code=%0d m=%0d exp 11/1/6", {result_valid, result_err}, result_code, core_m_rows);
      end
      ack();
   endtask

   task automatic test_reset_mid_job();
      send_cfg(16'd7, 16'd7, 16'd12, 16'd4);
      send_beat(16'h0077, 1'b0);
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if ({cfg_ready, idx_in_ready, idx_wr_en, core_start, result_valid} !== 5'b10000 ||
          core_m_rows !== 16'd0 || core_s_tokens !== 16'd0 || idx_wr_data !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_mid: cfg_rdy/idx_rdy/wr_en/start/rv=%b m=%0d s=%0d data=%h exp 10000/0/0/0",
                  {cfg_ready, idx_in_ready, idx_wr_en, core_start, result_valid}, core_m_rows, core_s_tokens, idx_wr_data);
      end
      @(negedge clk);
      rstn = 1'b1;
      tick();
      send_cfg(16'd3, 16'd4, 16'd12, 16'd4);
      send_beat(16'h00A1, 1'b0);
      n_checks++;
      if (idx_wr_en !== 1'b1 || idx_wr_addr !== 16'd0 || idx_wr_data !== 16'h00A1) begin
         n_fail++;
         $display("FAIL rst_resume_wr0: wr_en=%b addr=%h data=%h exp 1/0000/00a1", idx_wr_en, idx_wr_addr, idx_wr_data);
      end
      send_beat(16'h00A2, 1'b0);
      send_beat(16'h00A3, 1'b1);
      n_checks++;
      if (core_start !== 1'b1 || idx_wr_addr !== 16'd2) begin
         n_fail++;
         $display("FAIL rst_resume_start: start=%b addr=%h exp 1/0002", core_start, idx_wr_addr);
      end
      run_core(64'h1234_5678_9ABC_DEF0);
      n_checks++;
      if (result_valid !== 1'b1 || result_code !== 2'd0 || result_checksum !== 64'h1234_5678_9ABC_DEF0) begin
         n_fail++;
         $display("FAIL rst_resume_result: rv=%b code=%0d csum=%h exp 1/0/123456789abcdef0",
                  result_valid, result_code, result_checksum);
      end
      ack();
   endtask

   initial begin
      rstn = 1'b0;
      cfg_valid = 1'b0; cfg_m_rows = '0; cfg_head_dim_d = '0; cfg_s_tokens = '0; cfg_block_size = '0;
      idx_in_valid = 1'b0; idx_in_data = '0; idx_in_last = 1'b0;
      core_busy = 1'b0; core_done = 1'b0; core_checksum = JUNK;
      result_ready = 1'b0;
      test_reset();
      test_nominal();
      test_block_size_zero();
      test_sizing();
      test_last_errors();
      test_backpressure();
      test_reset_mid_job();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
